// File: rtl/minimac2_pkg.sv
// Shared constants for the minimac2 control interface: CSR register map,
// RX slot state encodings and STATUS bit positions.
package minimac2_pkg;

  localparam logic [4:0] REG_CTRL   = 5'd0;
  localparam logic [4:0] REG_MII    = 5'd1;
  localparam logic [4:0] REG_STATUS = 5'd2;
  localparam logic [4:0] REG_MASK   = 5'd3;
  localparam logic [4:0] REG_TXQ    = 5'd4;
  localparam logic [4:0] REG_TXADR  = 5'd5;
  localparam logic [4:0] REG_TXLEN  = 5'd6;
  localparam logic [4:0] REG_SLOT0  = 5'd8;

  localparam logic [1:0] SLOT_IDLE   = 2'b00;
  localparam logic [1:0] SLOT_LOADED = 2'b01;
  localparam logic [1:0] SLOT_DONE   = 2'b10;

  localparam int unsigned ST_RX_DONE  = 0;
  localparam int unsigned ST_TX_DONE  = 1;
  localparam int unsigned ST_RX_OVF   = 2;
  localparam int unsigned ST_TXQ_DROP = 3;

  // Slot i occupies three consecutive indices: STATE, ADR, COUNT.
  function automatic logic [4:0] slot_reg(input int unsigned slot, input int unsigned field);
    return 5'(32'(REG_SLOT0) + 3 * slot + field);
  endfunction

endpackage

// File: rtl/minimac2_txq.sv
// Synchronous descriptor FIFO for queued TX frames; flush empties it in one cycle.
module minimac2_txq #(
  parameter int unsigned DW    = 41,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            din,
  output logic [DW-1:0]            dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/minimac2_ctlif.sv
// CSR/control interface of the minimac2 MAC: RX slot bookkeeping, TX descriptor
// queue, W1C interrupt status and the PHY MII management pins.
module minimac2_ctlif
  import minimac2_pkg::*;
#(
  parameter logic [3:0]  csr_addr  = 4'h0,
  parameter int unsigned NSLOTS    = 4,
  parameter int unsigned COUNT_W   = 11,
  parameter int unsigned TXQ_DEPTH = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  output logic        irq_rx,
  output logic        irq_tx,
  output logic        rx_rst,
  output logic        tx_rst,
  output logic        rx_valid,
  output logic [29:0] rx_adr,
  input  logic        rx_resetcount,
  input  logic        rx_incrcount,
  input  logic        rx_endframe,
  input  logic        fifo_full,
  output logic        tx_valid,
  output logic [29:0] tx_adr,
  output logic [1:0]  tx_bytecount,
  input  logic        tx_next,
  output logic        phy_mii_clk,
  inout  wire         phy_mii_data
);

  localparam int unsigned SW = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;
  localparam int unsigned QW = $clog2(TXQ_DEPTH);
  localparam int unsigned DW = 30 + COUNT_W;

  logic               csr_sel, csr_wr, txlen_wr, txlen_nz;
  logic [4:0]         idx;
  logic [31:0]        rd_data;
  logic               mii_mdc, mii_oe, mii_do, mdi_s1, mdi_s2;
  logic [3:0]         status, mask, status_set, status_clr;
  logic [1:0]         slot_state [NSLOTS];
  logic [29:0]        slot_adr   [NSLOTS];
  logic [COUNT_W-1:0] slot_count [NSLOTS];
  logic [SW-1:0]      sel_slot;
  logic               slot_any;
  logic [29:0]        tx_stage;
  logic [COUNT_W-1:0] tx_remaining;
  logic               q_push, q_pop, q_full, q_empty;
  logic [QW:0]        q_level;
  logic [DW-1:0]      q_dout;
  logic               unused_csr_a;

  assign unused_csr_a = ^csr_a[9:5];
  assign csr_sel      = (csr_a[13:10] == csr_addr);
  assign idx          = csr_a[4:0];
  assign csr_wr       = csr_sel & csr_we;
  assign txlen_wr     = csr_wr && (idx == REG_TXLEN);
  assign txlen_nz     = |csr_di[COUNT_W-1:0];

  assign phy_mii_clk  = mii_mdc;
  assign phy_mii_data = mii_oe ? mii_do : 1'bz;

  assign q_push   = txlen_wr & txlen_nz & ~tx_rst & ~q_full;
  assign q_pop    = ~tx_rst & (tx_remaining == '0) & ~q_empty;
  assign tx_valid = (tx_remaining != '0);
  assign rx_adr   = slot_any ? slot_adr[sel_slot] : '0;

  minimac2_txq #(
    .DW    (DW),
    .DEPTH (TXQ_DEPTH)
  ) u_txq (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .flush (tx_rst),
    .push  (q_push),
    .pop   (q_pop),
    .din   ({tx_stage, csr_di[COUNT_W-1:0]}),
    .dout  (q_dout),
    .full  (q_full),
    .empty (q_empty),
    .level (q_level)
  );

  // Lowest-indexed loaded slot receives the datapath.
  always_comb begin
    sel_slot = '0;
    slot_any = 1'b0;
    rx_valid = 1'b0;
    for (int unsigned i = 0; i < NSLOTS; i++) begin
      rx_valid = rx_valid | slot_state[i][0];
      if (!slot_any && slot_state[i] == SLOT_LOADED) begin
        sel_slot = SW'(i);
        slot_any = 1'b1;
      end
    end
  end

  always_comb begin
    status_set = '0;
    status_set[ST_RX_DONE]  = rx_endframe & slot_any;
    status_set[ST_TX_DONE]  = ~tx_rst & tx_next & (tx_remaining == COUNT_W'(1));
    status_set[ST_RX_OVF]   = fifo_full;
    status_set[ST_TXQ_DROP] = txlen_wr & txlen_nz & ~tx_rst & q_full;
    status_clr = (csr_wr && idx == REG_STATUS) ? csr_di[3:0] : '0;
  end

  always_comb begin
    rd_data = '0;
    case (idx)
      REG_CTRL:   rd_data[1:0] = {tx_rst, rx_rst};
      REG_MII:    rd_data[3:0] = {mii_mdc, mii_oe, mdi_s2, mii_do};
      REG_STATUS: rd_data[3:0] = status;
      REG_MASK:   rd_data[3:0] = mask;
      REG_TXQ: begin
        rd_data[QW:0]     = (QW+1)'(TXQ_DEPTH) - q_level;
        rd_data[8+QW:8]   = q_level;
      end
      REG_TXADR:  rd_data = {tx_stage, 2'b00};
      default: begin
        for (int unsigned i = 0; i < NSLOTS; i++) begin
          if (idx == slot_reg(i, 0)) rd_data[1:0] = slot_state[i];
          if (idx == slot_reg(i, 1)) rd_data = {slot_adr[i], 2'b00};
          if (idx == slot_reg(i, 2)) rd_data[COUNT_W-1:0] = slot_count[i];
        end
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      csr_do       <= '0;
      irq_rx       <= 1'b0;
      irq_tx       <= 1'b0;
      rx_rst       <= 1'b1;
      tx_rst       <= 1'b1;
      mii_mdc      <= 1'b0;
      mii_oe       <= 1'b0;
      mii_do       <= 1'b0;
      mdi_s1       <= 1'b0;
      mdi_s2       <= 1'b0;
      status       <= '0;
      mask         <= '0;
      tx_stage     <= '0;
      tx_remaining <= '0;
      tx_adr       <= '0;
      tx_bytecount <= '0;
      for (int unsigned i = 0; i < NSLOTS; i++) begin
        slot_state[i] <= SLOT_IDLE;
        slot_adr[i]   <= '0;
        slot_count[i] <= '0;
      end
    end else begin
      csr_do <= csr_sel ? rd_data : '0;
      mdi_s1 <= phy_mii_data;
      mdi_s2 <= mdi_s1;
      status <= (status & ~status_clr) | status_set;
      irq_rx <= |({status[ST_TXQ_DROP], status[ST_RX_OVF], 1'b0, status[ST_RX_DONE]} & mask)
                | (rx_rst & mask[0]);
      irq_tx <= status[ST_TX_DONE] & mask[1];

      if (csr_wr) begin
        case (idx)
          REG_CTRL:  {tx_rst, rx_rst} <= csr_di[1:0];
          REG_MII:   {mii_mdc, mii_oe, mii_do} <= {csr_di[3], csr_di[2], csr_di[0]};
          REG_MASK:  mask <= csr_di[3:0];
          REG_TXADR: tx_stage <= csr_di[31:2];
          default:   ;
        endcase
      end
      if (fifo_full) rx_rst <= 1'b1;

      // Datapath updates come after CSR writes so they win on the same slot.
      for (int unsigned i = 0; i < NSLOTS; i++) begin
        if (csr_wr && idx == slot_reg(i, 0)) begin
          slot_state[i] <= csr_di[1:0];
          slot_count[i] <= '0;
        end
        if (csr_wr && idx == slot_reg(i, 1)) slot_adr[i] <= csr_di[31:2];
        if (slot_any && sel_slot == SW'(i)) begin
          if (rx_resetcount)
            slot_count[i] <= '0;
          else if (rx_incrcount && slot_count[i] != '1)
            slot_count[i] <= slot_count[i] + COUNT_W'(1);
          if (rx_endframe) slot_state[i] <= SLOT_DONE;
        end
      end

      if (tx_rst) begin
        tx_remaining <= '0;
      end else if (q_pop) begin
        tx_adr       <= q_dout[DW-1:COUNT_W];
        tx_remaining <= q_dout[COUNT_W-1:0];
        tx_bytecount <= '0;
      end else if (tx_next && tx_valid) begin
        tx_remaining <= tx_remaining - COUNT_W'(1);
        tx_bytecount <= tx_bytecount + 2'd1;
        if (tx_bytecount == 2'd3) tx_adr <= tx_adr + 30'd1;
      end
    end
  end

endmodule

// File: tb/tb_minimac2_ctlif.sv
// Directed self-checking bench for minimac2_ctlif, plus a COUNT_W=4 instance
// for the counter saturation boundary.
module tb_minimac2_ctlif;
  import minimac2_pkg::*;

  localparam logic [3:0]  BANK   = 4'h0;
  localparam logic [13:0] IDLE_A = 14'h3C00;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [13:0] csr_a = IDLE_A;
  logic        csr_we = 1'b0;
  logic [31:0] csr_di = '0;
  logic        rx_resetcount = 1'b0, rx_incrcount = 1'b0, rx_endframe = 1'b0;
  logic        fifo_full = 1'b0, tx_next = 1'b0;

  logic [31:0] csr_do, s_csr_do;
  logic        irq_rx, irq_tx, rx_rst, tx_rst, rx_valid, tx_valid, phy_mii_clk;
  logic [29:0] rx_adr, tx_adr;
  logic [1:0]  tx_bytecount;
  wire         phy_mii_data;

  logic        unused_s_irq_rx, unused_s_irq_tx, unused_s_rx_rst, unused_s_tx_rst;
  logic        unused_s_rx_valid, unused_s_tx_valid, unused_s_mdc;
  logic [29:0] unused_s_rx_adr, unused_s_tx_adr;
  logic [1:0]  unused_s_bc;
  wire         unused_s_mdio;

  int checks = 0;
  int errors = 0;
  logic [31:0] d, ds;

  logic [29:0] exp_adr [12] = '{30'h400, 30'h400, 30'h400, 30'h401, 30'h401, 30'h800,
                                30'h800, 30'hC00, 30'hC00, 30'hC00, 30'hC00, 30'hC01};
  logic [1:0]  exp_bc  [12] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd0,
                                2'd1, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic        exp_v   [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
                                1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  always #5 sys_clk = ~sys_clk;

  minimac2_ctlif u_dut (
    .sys_clk (sys_clk), .sys_rst (sys_rst),
    .csr_a (csr_a), .csr_we (csr_we), .csr_di (csr_di), .csr_do (csr_do),
    .irq_rx (irq_rx), .irq_tx (irq_tx), .rx_rst (rx_rst), .tx_rst (tx_rst),
    .rx_valid (rx_valid), .rx_adr (rx_adr),
    .rx_resetcount (rx_resetcount), .rx_incrcount (rx_incrcount),
    .rx_endframe (rx_endframe), .fifo_full (fifo_full),
    .tx_valid (tx_valid), .tx_adr (tx_adr), .tx_bytecount (tx_bytecount),
    .tx_next (tx_next), .phy_mii_clk (phy_mii_clk), .phy_mii_data (phy_mii_data)
  );

  minimac2_ctlif #(.COUNT_W(4)) u_dut4 (
    .sys_clk (sys_clk), .sys_rst (sys_rst),
    .csr_a (csr_a), .csr_we (csr_we), .csr_di (csr_di), .csr_do (s_csr_do),
    .irq_rx (unused_s_irq_rx), .irq_tx (unused_s_irq_tx),
    .rx_rst (unused_s_rx_rst), .tx_rst (unused_s_tx_rst),
    .rx_valid (unused_s_rx_valid), .rx_adr (unused_s_rx_adr),
    .rx_resetcount (rx_resetcount), .rx_incrcount (rx_incrcount),
    .rx_endframe (rx_endframe), .fifo_full (fifo_full),
    .tx_valid (unused_s_tx_valid), .tx_adr (unused_s_tx_adr),
    .tx_bytecount (unused_s_bc), .tx_next (tx_next),
    .phy_mii_clk (unused_s_mdc), .phy_mii_data (unused_s_mdio)
  );

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic csr_write(input logic [4:0] idx, input logic [31:0] data);
    csr_a  = {BANK, 5'd0, idx};
    csr_we = 1'b1;
    csr_di = data;
    tick();
    csr_we = 1'b0;
    csr_a  = IDLE_A;
  endtask

  task automatic csr_read(input logic [4:0] idx, output logic [31:0] data, output logic [31:0] sdata);
    csr_a = {BANK, 5'd0, idx};
    tick();
    data  = csr_do;
    sdata = s_csr_do;
    csr_a = IDLE_A;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) tick();
    sys_rst = 1'b0;

    // Reset state
    check("rst_csr_do", csr_do, 32'h0);
    check("rst_irq", {30'd0, irq_rx, irq_tx}, 32'h0);
    check("rst_ctrl_pins", {30'd0, tx_rst, rx_rst}, 32'h3);
    check("rst_valids", {30'd0, rx_valid, tx_valid}, 32'h0);
    check("rst_mdc", {31'd0, phy_mii_clk}, 32'h0);
    check("rst_tx_adr", {2'b0, tx_adr}, 32'h0);
    csr_read(REG_CTRL, d, ds);   check("rd_ctrl", d, 32'h3);
    csr_read(REG_MII, d, ds);    check("rd_mii", d & 32'hD, 32'h0);
    csr_read(REG_STATUS, d, ds); check("rd_status", d, 32'h0);
    csr_read(REG_MASK, d, ds);   check("rd_mask", d, 32'h0);
    csr_read(REG_TXQ, d, ds);    check("rd_txq", d, 32'h4);
    csr_read(REG_TXADR, d, ds);  check("rd_txadr", d, 32'h0);
    for (int i = 8; i < 20; i++) begin
      csr_read(5'(i), d, ds);
      check("rd_slot_reset", d, 32'h0);
    end
    csr_write(5'd7, 32'hFFFF_FFFF);
    csr_read(5'd7, d, ds);       check("rd_idx7", d, 32'h0);
    csr_a = {4'h1, 5'd0, REG_CTRL};
    tick();
    check("bank_unselected", csr_do, 32'h0);
    csr_a = IDLE_A;
    check("rst_irq_rx_mask0", {31'd0, irq_rx}, 32'h0);

    // MII management pins
    csr_write(REG_MII, 32'hD);
    check("mii_mdc", {31'd0, phy_mii_clk}, 32'h1);
    tick(); tick();
    csr_read(REG_MII, d, ds);    check("mii_loopback", d, 32'hF);
    csr_write(REG_MII, 32'h0);

    // RX slots 1 and 2
    csr_write(5'd12, 32'h100);
    csr_write(5'd15, 32'h200);
    csr_write(5'd11, 32'h1);
    csr_write(5'd14, 32'h1);
    csr_write(REG_CTRL, 32'h0);
    check("rx_valid_loaded", {31'd0, rx_valid}, 32'h1);
    rx_incrcount = 1'b1;
    repeat (5) tick();
    rx_incrcount = 1'b0;
    check("rx_adr_slot1", {2'b0, rx_adr}, 32'h40);
    rx_endframe = 1'b1;
    tick();
    rx_endframe = 1'b0;
    check("rx_adr_slot2", {2'b0, rx_adr}, 32'h80);
    csr_read(5'd11, d, ds);      check("slot1_state", d, 32'h2);
    csr_read(5'd13, d, ds);      check("slot1_count", d, 32'h5);
    csr_read(5'd12, d, ds);      check("slot1_adr", d, 32'h100);
    csr_read(5'd8, d, ds);       check("slot0_state", d, 32'h0);
    csr_write(REG_MASK, 32'h1);
    tick();
    check("irq_rx_done", {31'd0, irq_rx}, 32'h1);
    csr_read(REG_STATUS, d, ds); check("status_rx_done", d, 32'h1);
    csr_write(REG_STATUS, 32'h1);
    csr_read(REG_STATUS, d, ds); check("status_w1c", d, 32'h0);
    check("irq_rx_cleared", {31'd0, irq_rx}, 32'h0);

    // Count saturation on slot 2 and resetcount priority
    rx_incrcount = 1'b1;
    repeat (20) tick();
    rx_incrcount = 1'b0;
    csr_read(5'd16, d, ds);
    check("slot2_count_w11", d, 32'd20);
    check("slot2_count_w4_sat", ds, 32'd15);
    rx_incrcount = 1'b1;
    rx_resetcount = 1'b1;
    tick();
    rx_incrcount = 1'b0;
    rx_resetcount = 1'b0;
    csr_read(5'd16, d, ds);
    check("resetcount_prio", d, 32'h0);
    check("resetcount_prio_w4", ds, 32'h0);

    // TX queue: zero length ignored, three descriptors streamed
    csr_write(REG_MASK, 32'h2);
    csr_write(REG_TXLEN, 32'h0);
    tick();
    check("txlen0_no_valid", {31'd0, tx_valid}, 32'h0);
    csr_read(REG_TXQ, d, ds);    check("txlen0_txq", d, 32'h4);
    csr_write(REG_TXADR, 32'h1000);
    csr_write(REG_TXLEN, 32'd5);
    csr_write(REG_TXADR, 32'h2000);
    csr_write(REG_TXLEN, 32'd1);
    csr_write(REG_TXADR, 32'h3000);
    csr_write(REG_TXLEN, 32'd4);
    check("tx_first_load", {tx_valid, tx_bytecount, tx_adr[28:0]}, {1'b1, 2'd0, 29'h400});
    csr_read(REG_TXQ, d, ds);    check("txq_levels", d, 32'h0202);
    tx_next = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      check($sformatf("tx_step%0d", k + 1), {tx_valid, tx_bytecount, tx_adr[28:0]},
            {exp_v[k], exp_bc[k], exp_adr[k][28:0]});
    end
    tx_next = 1'b0;
    csr_read(REG_STATUS, d, ds); check("status_tx_done", d, 32'h2);
    check("irq_tx", {31'd0, irq_tx}, 32'h1);
    csr_read(REG_TXQ, d, ds);    check("txq_drained", d, 32'h4);
    csr_write(REG_STATUS, 32'h2);

    // Queue overflow
    for (int k = 0; k < 6; k++) begin
      csr_write(REG_TXADR, 32'h4000);
      csr_write(REG_TXLEN, 32'(k + 1));
    end
    check("ovf_current", {tx_valid, tx_bytecount, tx_adr[28:0]}, {1'b1, 2'd0, 29'h1000});
    csr_read(REG_TXQ, d, ds);    check("ovf_txq_full", d, 32'h0400);
    csr_read(REG_STATUS, d, ds); check("ovf_drop", d, 32'h8);
    csr_write(REG_STATUS, 32'h8);
    csr_read(REG_STATUS, d, ds); check("ovf_drop_cleared", d, 32'h0);

    // tx_rst flush, push ignored while held
    csr_write(REG_CTRL, 32'h2);
    csr_write(REG_TXLEN, 32'd3);
    check("flush_tx_valid", {31'd0, tx_valid}, 32'h0);
    check("flush_tx_rst", {31'd0, tx_rst}, 32'h1);
    csr_read(REG_TXQ, d, ds);    check("flush_txq", d, 32'h4);
    csr_write(REG_CTRL, 32'h0);

    // fifo_full beats W1C and a CTRL write clearing rx_rst
    fifo_full = 1'b1;
    csr_write(REG_STATUS, 32'h4);
    fifo_full = 1'b0;
    check("ovf_rx_rst", {31'd0, rx_rst}, 32'h1);
    csr_read(REG_STATUS, d, ds); check("ovf_set_beats_clr", d, 32'h4);
    fifo_full = 1'b1;
    csr_write(REG_CTRL, 32'h0);
    fifo_full = 1'b0;
    check("ovf_beats_ctrl", {31'd0, rx_rst}, 32'h1);
    csr_write(REG_CTRL, 32'h0);
    check("ctrl_clear_rx_rst", {31'd0, rx_rst}, 32'h0);
    csr_write(REG_STATUS, 32'h4);
    csr_read(REG_STATUS, d, ds); check("ovf_cleared", d, 32'h0);
    csr_write(REG_MASK, 32'h1);
    csr_write(REG_CTRL, 32'h1);
    tick();
    check("irq_rx_from_rx_rst", {31'd0, irq_rx}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
